// File: rtl/instr_rom_loader_pkg.sv
// Shared types for the 4-bit cpu instruction memory and its loader.
//   addr_t         : cpu fetch address {mode[1:0], word[3:0]}; the packed
//                    value is the physical word address
//   data_t         : instruction {opcode[3:0], imm[3:0]}
//   loader_state_t : program loader FSM states
//   BANK_WORDS     : words per mode bank
package instr_rom_loader_pkg;

  localparam int unsigned BANK_WORDS = 16;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] word;
  } addr_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] imm;
  } data_t;

  typedef enum logic [2:0] {
    HALT,
    RUN,
    LOAD,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/instr_rom_loader_rom_bank_array.sv
// rom_bank_array: BANKS*16 x 8 register array backing the instruction memory.
//   clock, reset : system clock, synchronous active-low clear of every word
//   rd_addr      : combinational read address (mode >= BANKS reads 8'h00)
//   rd_data      : word at rd_addr, zero latency, shows the pre-write value
//                  when written in the same cycle
//   wr_en        : write strobe, takes effect at the next clock edge
//   wr_addr      : physical word address to write
//   wr_data      : word to write
module rom_bank_array
  import instr_rom_loader_pkg::*;
#(
  parameter int unsigned BANKS = 2,
  localparam int unsigned WORDS = BANKS * BANK_WORDS,
  localparam int unsigned AW = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  addr_t         rd_addr,
  output data_t         rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  data_t         wr_data
);

  localparam logic [2:0] NBANKS = 3'(BANKS);

  data_t mem_q [WORDS];
  data_t mem_d [WORDS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Unimplemented banks read as zero; the low AW bits index the implemented words.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr.mode} < NBANKS) begin
      rd_data = mem_q[rd_addr[AW-1:0]];
    end
  end

endmodule

// File: rtl/instr_rom_loader.sv
// instr_rom_loader: instruction-memory responder and run-time program loader.
//   clock, reset : system clock, synchronous active-low reset
//   addr, data   : cpu fetch port, combinational read
//   cpu_run      : active-low cpu reset, low while a program loads
//   prog_start   : pulse that restarts a load at word 0 (beats that cycle are dropped)
//   prog_valid/prog_ready/prog_data/prog_last : byte-stream load handshake
//   prog_busy    : high in LOAD and DONE
//   prog_error   : sticky overflow flag, cleared by prog_start or reset
//   checksum     : mod-256 sum of bytes accepted since the last prog_start
module instr_rom_loader
  import instr_rom_loader_pkg::*;
#(
  parameter int unsigned BANKS    = 2,
  parameter bit          INIT_RUN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  addr_t      addr,
  output data_t      data,
  output logic       cpu_run,
  input  logic       prog_start,
  input  logic       prog_valid,
  output logic       prog_ready,
  input  logic [7:0] prog_data,
  input  logic       prog_last,
  output logic       prog_busy,
  output logic       prog_error,
  output logic [7:0] checksum
);

  localparam int unsigned AW = $clog2(BANKS * BANK_WORDS);
  localparam logic [AW-1:0] LAST_WP = AW'(BANKS * BANK_WORDS - 1);

  loader_state_t state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [7:0]    checksum_q, checksum_d;
  logic          cpu_run_q, cpu_run_d;
  logic          prog_ready_q, prog_ready_d;
  logic          prog_busy_q, prog_busy_d;
  logic          prog_error_q, prog_error_d;
  logic          wr_en;

  rom_bank_array #(.BANKS(BANKS)) u_mem (
    .clock   (clock),
    .reset   (reset),
    .rd_addr (addr),
    .rd_data (data),
    .wr_en   (wr_en),
    .wr_addr (wp_q),
    .wr_data (prog_data)
  );

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    checksum_d = checksum_q;
    wr_en      = 1'b0;
    if (prog_start) begin
      state_d    = LOAD;
      wp_d       = '0;
      checksum_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (prog_valid && prog_ready_q) begin
            wr_en      = 1'b1;
            wp_d       = wp_q + AW'(1);
            checksum_d = checksum_q + prog_data;
            if (prog_last) begin
              state_d = DONE;
            end else if (wp_q == LAST_WP) begin
              state_d = ERROR;
            end
          end
        end
        DONE:    state_d = RUN;
        default: state_d = state_q;
      endcase
    end
    // Outputs are registered, so they are decoded from the next state.
    cpu_run_d    = (state_d == RUN);
    prog_ready_d = (state_d == LOAD);
    prog_busy_d  = (state_d == LOAD) || (state_d == DONE);
    prog_error_d = (state_d == ERROR);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= INIT_RUN ? RUN : HALT;
      wp_q         <= '0;
      checksum_q   <= '0;
      cpu_run_q    <= INIT_RUN;
      prog_ready_q <= 1'b0;
      prog_busy_q  <= 1'b0;
      prog_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      checksum_q   <= checksum_d;
      cpu_run_q    <= cpu_run_d;
      prog_ready_q <= prog_ready_d;
      prog_busy_q  <= prog_busy_d;
      prog_error_q <= prog_error_d;
    end
  end

  assign cpu_run    = cpu_run_q;
  assign prog_ready = prog_ready_q;
  assign prog_busy  = prog_busy_q;
  assign prog_error = prog_error_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_instr_rom_loader.sv
// Directed bench for instr_rom_loader (BANKS=2, INIT_RUN=1).
module tb_instr_rom_loader;
  import instr_rom_loader_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  addr_t      addr = '0;
  data_t      data;
  logic       cpu_run;
  logic       prog_start = 1'b0;
  logic       prog_valid = 1'b0;
  logic       prog_ready;
  logic [7:0] prog_data = '0;
  logic       prog_last = 1'b0;
  logic       prog_busy;
  logic       prog_error;
  logic [7:0] checksum;

  int unsigned total = 0;
  int unsigned bad = 0;

  instr_rom_loader #(.BANKS(2), .INIT_RUN(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .addr       (addr),
    .data       (data),
    .cpu_run    (cpu_run),
    .prog_start (prog_start),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_data  (prog_data),
    .prog_last  (prog_last),
    .prog_busy  (prog_busy),
    .prog_error (prog_error),
    .checksum   (checksum)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int unsigned a, input logic [7:0] exp, input string tag);
    addr = addr_t'(a[5:0]);
    #1;
    chk(tag, 32'(data), 32'(exp));
  endtask

  task automatic start();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    prog_valid = 1'b1;
    prog_data  = d;
    prog_last  = l;
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_sum;

    // Reset state
    tick();
    tick();
    reset = 1'b1;
    chk("rst_cpu_run", 32'(cpu_run), 32'd1);
    chk("rst_ready", 32'(prog_ready), 32'd0);
    chk("rst_busy", 32'(prog_busy), 32'd0);
    chk("rst_error", 32'(prog_error), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    for (int a = 0; a < 64; a++) rd(a, 8'h00, "rst_mem");

    // Basic three-beat load
    start();
    chk("ld_cpu_run_low", 32'(cpu_run), 32'd0);
    chk("ld_ready", 32'(prog_ready), 32'd1);
    chk("ld_busy", 32'(prog_busy), 32'd1);
    beat(8'hB3, 1'b0);
    beat(8'h01, 1'b0);
    beat(8'hF0, 1'b1);
    chk("done_ready", 32'(prog_ready), 32'd0);
    chk("done_busy", 32'(prog_busy), 32'd1);
    chk("done_cpu_run", 32'(cpu_run), 32'd0);
    chk("ld_checksum", 32'(checksum), 32'hA4);
    tick();
    chk("run_cpu_run", 32'(cpu_run), 32'd1);
    chk("run_busy", 32'(prog_busy), 32'd0);
    rd(0, 8'hB3, "ld_w0");
    rd(1, 8'h01, "ld_w1");
    rd(2, 8'hF0, "ld_w2");
    rd(3, 8'h00, "ld_w3");

    // Throttled load: valid on even cycles only
    start();
    exp_sum = 8'h00;
    for (int i = 0; i < 7; i++) begin
      prog_valid = (i % 2 == 0);
      prog_data  = 8'h10 + 8'(i);
      prog_last  = (i == 6);
      if (i % 2 == 0) exp_sum = exp_sum + 8'h10 + 8'(i);
      tick();
      chk("thr_checksum", 32'(checksum), 32'(exp_sum));
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    chk("thr_sum_final", 32'(checksum), 32'h4C);
    tick();
    chk("thr_cpu_run", 32'(cpu_run), 32'd1);
    rd(0, 8'h10, "thr_w0");
    rd(1, 8'h12, "thr_w1");
    rd(2, 8'h14, "thr_w2");
    rd(3, 8'h16, "thr_w3");
    rd(4, 8'h00, "thr_w4");

    // Overflow: 33 beats without prog_last
    start();
    for (int i = 0; i < 33; i++) beat(8'(i + 1), 1'b0);
    chk("ovf_error", 32'(prog_error), 32'd1);
    chk("ovf_ready", 32'(prog_ready), 32'd0);
    chk("ovf_cpu_run", 32'(cpu_run), 32'd0);
    chk("ovf_busy", 32'(prog_busy), 32'd0);
    chk("ovf_checksum", 32'(checksum), 32'h10);
    for (int a = 0; a < 32; a++) rd(a, 8'(a + 1), "ovf_mem");
    rd(6'h20, 8'h00, "ovf_mode2");
    rd(6'h30, 8'h00, "ovf_mode3");
    tick();
    chk("err_sticky", 32'(prog_error), 32'd1);
    start();
    chk("err_cleared", 32'(prog_error), 32'd0);
    chk("err_restart_sum", 32'(checksum), 32'd0);

    // prog_start with a valid beat mid-load
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b0);
    chk("mid_sum", 32'(checksum), 32'h65);
    prog_valid = 1'b1;
    prog_data  = 8'hCC;
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    prog_valid = 1'b0;
    chk("restart_sum", 32'(checksum), 32'd0);
    rd(2, 8'h03, "restart_w2_unwritten");
    rd(0, 8'hAA, "restart_w0_old");
    // Collision: old word visible during the write cycle
    addr = '0;
    prog_valid = 1'b1;
    prog_data  = 8'hDD;
    prog_last  = 1'b1;
    #1;
    chk("coll_old", 32'(data), 32'hAA);
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    chk("coll_new", 32'(data), 32'hDD);
    chk("restart_wp0_sum", 32'(checksum), 32'hDD);
    rd(2, 8'h03, "restart_w2_final");
    tick();
    chk("restart_run", 32'(cpu_run), 32'd1);

    // Reset in the middle of a load
    start();
    beat(8'h55, 1'b0);
    beat(8'h66, 1'b0);
    reset = 1'b0;
    tick();
    chk("mrst_cpu_run", 32'(cpu_run), 32'd1);
    chk("mrst_ready", 32'(prog_ready), 32'd0);
    chk("mrst_busy", 32'(prog_busy), 32'd0);
    chk("mrst_checksum", 32'(checksum), 32'd0);
    for (int a = 0; a < 32; a++) rd(a, 8'h00, "mrst_mem");
    reset = 1'b1;
    tick();
    rd(6'h20, 8'h00, "mrst_mode2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
